// File: rtl/pc_pkg.sv
// Shared encodings and helpers for the nested-interrupt program counter.
package pc_pkg;

    // Adder base select
    typedef enum logic [1:0] {
        PC_BASEX_PC   = 2'b00,
        PC_BASEX_REGB = 2'b01,
        PC_BASEX_ZERO = 2'b10
    } pc_basex_e;

    // Adder offset select
    typedef enum logic [1:0] {
        PC_OFFSETX_ZERO = 2'b00,
        PC_OFFSETX_TWO  = 2'b01,
        PC_OFFSETX_FOUR = 2'b10,
        PC_OFFSETX_DIN  = 2'b11
    } pc_offsetx_e;

    localparam int unsigned PC_OFFSET_TWO  = 2;
    localparam int unsigned PC_OFFSET_FOUR = 4;

    // Level register holds 0..NUM_INT, where NUM_INT means "no interrupt active"
    function automatic int level_width(input int num_int);
        return $clog2(num_int + 1);
    endfunction

endpackage

// File: rtl/pc_return_stack.sv
// LIFO of {return address, saved level}; top entry readable combinationally so a
// pop can restore PC_A in the same update cycle.
module pc_return_stack #(
    parameter int DEPTH = 2,
    parameter int W     = 18
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty
);
    localparam int SPW = $clog2(DEPTH + 1);
    localparam int IW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [W-1:0]   mem [DEPTH];
    logic [SPW-1:0] sp_reg;
    logic [SPW-1:0] sp_dec;
    logic [IW-1:0]  wr_idx;
    logic [IW-1:0]  rd_idx;

    assign sp_dec = sp_reg - SPW'(1);
    assign wr_idx = IW'(sp_reg);
    assign rd_idx = IW'(sp_dec);
    assign full   = (sp_reg == SPW'(DEPTH));
    assign empty  = (sp_reg == '0);
    assign dout   = mem[rd_idx];

    // Entry contents need no reset: only entries below SP are ever read back.
    always_ff @(posedge clk) begin
        if (push && !full) begin
            mem[wr_idx] <= din;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sp_reg <= '0;
        end else if (pop && !empty) begin
            sp_reg <= sp_dec;
        end else if (push && !full) begin
            sp_reg <= sp_reg + SPW'(1);
        end
    end

endmodule

// File: rtl/pc_nested_int.sv
// Program counter with base+offset adder, HERE register and prioritised nestable
// interrupts. Optional PC_INT_MASK_EN adds a per-channel mask register loaded from DIN.
module pc_nested_int
    import pc_pkg::*;
#(
    parameter int          AW         = 16,
    parameter int          NUM_INT    = 2,
    parameter int          DEPTH      = 2,
    parameter int unsigned RESET_ADDR = 32'hFFFE,
    parameter int unsigned VEC_BASE   = 32'h0004,
    parameter int unsigned VEC_STRIDE = 32'h0004,
    localparam int         LW         = level_width(NUM_INT)
) (
    input  logic               CLK,
    input  logic               RESET_N,
    input  logic               FETCH,
    input  logic               DECODE,
    input  logic               PC_EN,
    input  logic [1:0]         PC_BASEX,
    input  logic [1:0]         PC_OFFSETX,
    input  logic [AW-1:0]      REGB_DOUT,
    input  logic [AW-1:0]      DIN,
    input  logic               RETI,
    input  logic               INT_EN,
    input  logic [NUM_INT-1:0] INT_REQ,
    input  logic               MASK_WE,
    output logic [AW-1:0]      PC_A,
    output logic [AW-1:0]      PC_A_NEXT,
    output logic [AW-1:0]      HERE,
    output logic [NUM_INT-1:0] INT_ACK,
    output logic [LW-1:0]      INT_LEVEL,
    output logic               STACK_FULL,
    output logic               RET_ERR
);
    logic [AW-1:0]      arga;
    logic [AW-1:0]      argb;
    logic [AW-1:0]      sum;
    logic [NUM_INT-1:0] int_mask;
    logic [NUM_INT-1:0] masked_req;
    logic [LW-1:0]      sel;
    logic [AW-1:0]      vector;
    logic               update;
    logic               take;
    logic               do_pop;
    logic               do_push;
    logic               stack_empty;
    logic [AW+LW-1:0]   stack_top;
    logic [NUM_INT-1:0] ack_next;

    logic [AW-1:0]      pc_a_reg;
    logic [AW-1:0]      here_reg;
    logic [LW-1:0]      level_reg;
    logic [NUM_INT-1:0] ack_reg;
    logic               ret_err_reg;

    always_comb begin
        case (PC_BASEX)
            PC_BASEX_PC:   arga = pc_a_reg;
            PC_BASEX_REGB: arga = REGB_DOUT;
            default:       arga = '0;
        endcase
    end

    always_comb begin
        case (PC_OFFSETX)
            PC_OFFSETX_TWO:  argb = AW'(PC_OFFSET_TWO);
            PC_OFFSETX_FOUR: argb = AW'(PC_OFFSET_FOUR);
            PC_OFFSETX_DIN:  argb = DIN;
            default:         argb = '0;
        endcase
    end

    assign sum       = arga + argb;
    assign PC_A_NEXT = sum;

`ifdef PC_INT_MASK_EN
    logic [NUM_INT-1:0] mask_reg;

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            mask_reg <= '1;
        end else if (MASK_WE) begin
            mask_reg <= DIN[NUM_INT-1:0];
        end
    end

    assign int_mask = mask_reg;
`else
    logic unused_mask_we;

    assign unused_mask_we = MASK_WE;
    assign int_mask       = '1;
`endif

    assign masked_req = INT_REQ & int_mask;

    // sel == NUM_INT when nothing is requested, which never compares below the level.
    always_comb begin
        sel = LW'(NUM_INT);
        for (int i = NUM_INT - 1; i >= 0; i--) begin
            if (masked_req[i]) begin
                sel = LW'(i);
            end
        end
    end

    assign vector  = AW'(VEC_BASE) + AW'(sel) * AW'(VEC_STRIDE);
    assign update  = PC_EN & FETCH;
    assign take    = INT_EN & !STACK_FULL & (sel < level_reg);
    assign do_pop  = update & RETI & !stack_empty;
    assign do_push = update & !RETI & take;

    for (genvar gi = 0; gi < NUM_INT; gi++) begin : g_ack
        assign ack_next[gi] = do_push && (sel == LW'(gi));
    end

    pc_return_stack #(
        .DEPTH (DEPTH),
        .W     (AW + LW)
    ) u_stack (
        .clk   (CLK),
        .rst_n (RESET_N),
        .push  (do_push),
        .pop   (do_pop),
        .din   ({sum, level_reg}),
        .dout  (stack_top),
        .full  (STACK_FULL),
        .empty (stack_empty)
    );

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            pc_a_reg    <= AW'(RESET_ADDR);
            level_reg   <= LW'(NUM_INT);
            ret_err_reg <= 1'b0;
        end else if (update) begin
            if (RETI && !stack_empty) begin
                pc_a_reg  <= stack_top[AW+LW-1:LW];
                level_reg <= stack_top[LW-1:0];
            end else if (RETI) begin
                pc_a_reg    <= sum;
                ret_err_reg <= 1'b1;
            end else if (take) begin
                pc_a_reg  <= vector;
                level_reg <= sel;
            end else begin
                pc_a_reg <= sum;
            end
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            here_reg <= '0;
        end else if (PC_EN && DECODE) begin
            here_reg <= sum;
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            ack_reg <= '0;
        end else begin
            ack_reg <= ack_next;
        end
    end

    assign PC_A      = pc_a_reg;
    assign HERE      = here_reg;
    assign INT_ACK   = ack_reg;
    assign INT_LEVEL = level_reg;
    assign RET_ERR   = ret_err_reg;

endmodule

// File: tb/tb_pc_nested_int.sv
// Directed self-checking bench for pc_nested_int; u_dut uses DEPTH=2, u_dut1 uses DEPTH=1.
module tb_pc_nested_int;
    import pc_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        fetch = 1'b0;
    logic        decode = 1'b0;
    logic        pc_en = 1'b0;
    logic [1:0]  pc_basex = 2'b00;
    logic [1:0]  pc_offsetx = 2'b00;
    logic [15:0] regb_dout = '0;
    logic [15:0] din = '0;
    logic        reti = 1'b0;
    logic        int_en = 1'b1;
    logic [1:0]  int_req = 2'b00;
    logic        mask_we = 1'b0;

    logic [15:0] pc_a, pc_a_next, here;
    logic [1:0]  int_ack, int_level;
    logic        stack_full, ret_err;
    logic [15:0] pc_a1, pc_a_next1, here1;
    logic [1:0]  int_ack1, int_level1;
    logic        stack_full1, ret_err1;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    pc_nested_int #(.DEPTH(2)) u_dut (
        .CLK(clk), .RESET_N(rst_n), .FETCH(fetch), .DECODE(decode), .PC_EN(pc_en),
        .PC_BASEX(pc_basex), .PC_OFFSETX(pc_offsetx), .REGB_DOUT(regb_dout), .DIN(din),
        .RETI(reti), .INT_EN(int_en), .INT_REQ(int_req), .MASK_WE(mask_we),
        .PC_A(pc_a), .PC_A_NEXT(pc_a_next), .HERE(here), .INT_ACK(int_ack),
        .INT_LEVEL(int_level), .STACK_FULL(stack_full), .RET_ERR(ret_err)
    );

    pc_nested_int #(.DEPTH(1)) u_dut1 (
        .CLK(clk), .RESET_N(rst_n), .FETCH(fetch), .DECODE(decode), .PC_EN(pc_en),
        .PC_BASEX(pc_basex), .PC_OFFSETX(pc_offsetx), .REGB_DOUT(regb_dout), .DIN(din),
        .RETI(reti), .INT_EN(int_en), .INT_REQ(int_req), .MASK_WE(mask_we),
        .PC_A(pc_a1), .PC_A_NEXT(pc_a_next1), .HERE(here1), .INT_ACK(int_ack1),
        .INT_LEVEL(int_level1), .STACK_FULL(stack_full1), .RET_ERR(ret_err1)
    );

    // One update cycle (PC_EN & FETCH); returns at the following falling edge.
    task automatic do_update(input logic [1:0] b, input logic [1:0] o, input logic r);
        pc_basex = b; pc_offsetx = o; reti = r; pc_en = 1'b1; fetch = 1'b1;
        @(posedge clk);
        @(negedge clk);
        pc_en = 1'b0; fetch = 1'b0; reti = 1'b0;
        $display("update base=%0d off=%0d reti=%0d req=%b -> pc=%h ack=%b lvl=%0d",
                 b, o, r, int_req, pc_a, int_ack, int_level);
    endtask

    task automatic set_pc(input logic [15:0] addr);
        din = addr;
        do_update(PC_BASEX_ZERO, PC_OFFSETX_DIN, 1'b0);
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        $display("reset pulse");
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checks++; if (pc_a !== 16'hFFFE) begin failures++; $display("FAIL reset_pc got=%h exp=%h", pc_a, 16'hFFFE); end
        checks++; if (here !== 16'h0000) begin failures++; $display("FAIL reset_here got=%h exp=0000", here); end
        checks++; if (int_level !== 2'd2) begin failures++; $display("FAIL reset_level got=%0d exp=2", int_level); end
        checks++; if (int_ack !== 2'b00 || stack_full !== 1'b0 || ret_err !== 1'b0) begin
            failures++; $display("FAIL reset_flags ack=%b full=%b err=%b exp=00/0/0", int_ack, stack_full, ret_err); end
        rst_n = 1'b1;
        pc_basex = PC_BASEX_PC; pc_offsetx = PC_OFFSETX_TWO;
        #1;
        checks++; if (pc_a_next !== 16'h0000) begin failures++; $display("FAIL reset_next got=%h exp=0000", pc_a_next); end
        @(negedge clk);
        do_update(PC_BASEX_PC, PC_OFFSETX_TWO, 1'b0);
        checks++; if (pc_a !== 16'h0000) begin failures++; $display("FAIL first_fetch got=%h exp=0000", pc_a); end
        checks++; if (here !== 16'h0000) begin failures++; $display("FAIL here_before_decode got=%h exp=0000", here); end
        pc_basex = PC_BASEX_PC; pc_offsetx = PC_OFFSETX_FOUR; pc_en = 1'b1; decode = 1'b1;
        @(posedge clk);
        @(negedge clk);
        pc_en = 1'b0; decode = 1'b0;
        $display("decode -> here=%h pc=%h", here, pc_a);
        checks++; if (here !== 16'h0004) begin failures++; $display("FAIL here_decode got=%h exp=0004", here); end
        checks++; if (pc_a !== 16'h0000) begin failures++; $display("FAIL pc_hold_decode got=%h exp=0000", pc_a); end
    endtask

    task automatic test_adder();
        regb_dout = 16'h1234; din = 16'hFFFF;
        pc_basex = PC_BASEX_REGB; pc_offsetx = PC_OFFSETX_DIN;
        #1;
        checks++; if (pc_a_next !== 16'h1233) begin failures++; $display("FAIL adder_wrap got=%h exp=1233", pc_a_next); end
        pc_basex = PC_BASEX_ZERO; pc_offsetx = PC_OFFSETX_FOUR;
        #1;
        checks++; if (pc_a_next !== 16'h0004) begin failures++; $display("FAIL adder_zero4 got=%h exp=0004", pc_a_next); end
        pc_basex = PC_BASEX_REGB; pc_offsetx = PC_OFFSETX_ZERO;
        #1;
        checks++; if (pc_a_next !== 16'h1234) begin failures++; $display("FAIL adder_regb got=%h exp=1234", pc_a_next); end
        @(negedge clk);
    endtask

    task automatic test_int_take_nest();
        int_req = 2'b00;
        set_pc(16'h0010);
        int_req = 2'b10;
        do_update(PC_BASEX_PC, PC_OFFSETX_TWO, 1'b0);
        checks++; if (pc_a !== 16'h0008) begin failures++; $display("FAIL take1_pc got=%h exp=0008", pc_a); end
        checks++; if (int_ack !== 2'b10) begin failures++; $display("FAIL take1_ack got=%b exp=10", int_ack); end
        checks++; if (int_level !== 2'd1) begin failures++; $display("FAIL take1_level got=%0d exp=1", int_level); end
        @(negedge clk);
        checks++; if (int_ack !== 2'b00) begin failures++; $display("FAIL take1_ack_drop got=%b exp=00", int_ack); end
        int_req = 2'b01;
        do_update(PC_BASEX_PC, PC_OFFSETX_TWO, 1'b0);
        checks++; if (pc_a !== 16'h0004) begin failures++; $display("FAIL nest_pc got=%h exp=0004", pc_a); end
        checks++; if (int_ack !== 2'b01 || int_level !== 2'd0) begin
            failures++; $display("FAIL nest_ack_level ack=%b lvl=%0d exp=01/0", int_ack, int_level); end
        checks++; if (stack_full !== 1'b1) begin failures++; $display("FAIL nest_full got=%b exp=1", stack_full); end
        int_req = 2'b00;
        do_update(PC_BASEX_PC, PC_OFFSETX_TWO, 1'b1);
        checks++; if (pc_a !== 16'h000A || int_level !== 2'd1) begin
            failures++; $display("FAIL reti1 pc=%h lvl=%0d exp=000a/1", pc_a, int_level); end
        do_update(PC_BASEX_PC, PC_OFFSETX_TWO, 1'b1);
        checks++; if (pc_a !== 16'h0012 || int_level !== 2'd2) begin
            failures++; $display("FAIL reti2 pc=%h lvl=%0d exp=0012/2", pc_a, int_level); end
        checks++; if (stack_full !== 1'b0) begin failures++; $display("FAIL reti2_full got=%b exp=0", stack_full); end
    endtask

    task automatic test_pending_lower();
        set_pc(16'h0030);
        int_req = 2'b01;
        do_update(PC_BASEX_PC, PC_OFFSETX_TWO, 1'b0);
        checks++; if (pc_a !== 16'h0004) begin failures++; $display("FAIL pend_take0 got=%h exp=0004", pc_a); end
        int_req = 2'b10;
        do_update(PC_BASEX_PC, PC_OFFSETX_TWO, 1'b0);
        checks++; if (pc_a !== 16'h0006 || int_ack !== 2'b00 || int_level !== 2'd0) begin
            failures++; $display("FAIL pend_held pc=%h ack=%b lvl=%0d exp=0006/00/0", pc_a, int_ack, int_level); end
        do_update(PC_BASEX_PC, PC_OFFSETX_TWO, 1'b1);
        checks++; if (pc_a !== 16'h0032 || int_ack !== 2'b00 || int_level !== 2'd2) begin
            failures++; $display("FAIL pend_reti pc=%h ack=%b lvl=%0d exp=0032/00/2", pc_a, int_ack, int_level); end
        do_update(PC_BASEX_PC, PC_OFFSETX_TWO, 1'b0);
        checks++; if (pc_a !== 16'h0008 || int_ack !== 2'b10 || int_level !== 2'd1) begin
            failures++; $display("FAIL pend_take1 pc=%h ack=%b lvl=%0d exp=0008/10/1", pc_a, int_ack, int_level); end
        int_req = 2'b00;
        do_update(PC_BASEX_PC, PC_OFFSETX_TWO, 1'b1);
        checks++; if (pc_a !== 16'h0034) begin failures++; $display("FAIL pend_ret got=%h exp=0034", pc_a); end
    endtask

    task automatic test_ret_err_int_en();
        set_pc(16'h0020);
        checks++; if (ret_err !== 1'b0) begin failures++; $display("FAIL err_before got=%b exp=0", ret_err); end
        do_update(PC_BASEX_PC, PC_OFFSETX_TWO, 1'b1);
        checks++; if (pc_a !== 16'h0022 || ret_err !== 1'b1) begin
            failures++; $display("FAIL reti_empty pc=%h err=%b exp=0022/1", pc_a, ret_err); end
        int_en = 1'b0; int_req = 2'b01;
        do_update(PC_BASEX_PC, PC_OFFSETX_TWO, 1'b0);
        checks++; if (pc_a !== 16'h0024 || int_ack !== 2'b00 || int_level !== 2'd2) begin
            failures++; $display("FAIL int_en_off pc=%h ack=%b lvl=%0d exp=0024/00/2", pc_a, int_ack, int_level); end
        checks++; if (ret_err !== 1'b1) begin failures++; $display("FAIL err_sticky got=%b exp=1", ret_err); end
        int_en = 1'b1; int_req = 2'b00;
    endtask

    task automatic test_mask();
        pulse_reset();
        checks++; if (ret_err !== 1'b0) begin failures++; $display("FAIL err_cleared got=%b exp=0", ret_err); end
        din = 16'h0001; mask_we = 1'b1;
        @(negedge clk);
        mask_we = 1'b0;
        int_req = 2'b10;
        do_update(PC_BASEX_PC, PC_OFFSETX_TWO, 1'b0);
`ifdef PC_INT_MASK_EN
        checks++; if (pc_a !== 16'h0000 || int_ack !== 2'b00 || int_level !== 2'd2) begin
            failures++; $display("FAIL masked pc=%h ack=%b lvl=%0d exp=0000/00/2", pc_a, int_ack, int_level); end
`else
        checks++; if (pc_a !== 16'h0008 || int_ack !== 2'b10 || int_level !== 2'd1) begin
            failures++; $display("FAIL mask_ignored pc=%h ack=%b lvl=%0d exp=0008/10/1", pc_a, int_ack, int_level); end
`endif
        int_req = 2'b00;
    endtask

    task automatic test_depth1_async_reset();
        pulse_reset();
        set_pc(16'h0010);
        int_req = 2'b10;
        do_update(PC_BASEX_PC, PC_OFFSETX_TWO, 1'b0);
        checks++; if (pc_a1 !== 16'h0008 || stack_full1 !== 1'b1) begin
            failures++; $display("FAIL d1_take1 pc=%h full=%b exp=0008/1", pc_a1, stack_full1); end
        int_req = 2'b11;
        do_update(PC_BASEX_PC, PC_OFFSETX_TWO, 1'b0);
        checks++; if (pc_a1 !== 16'h000A || int_ack1 !== 2'b00 || int_level1 !== 2'd1) begin
            failures++; $display("FAIL d1_blocked pc=%h ack=%b lvl=%0d exp=000a/00/1", pc_a1, int_ack1, int_level1); end
        do_update(PC_BASEX_PC, PC_OFFSETX_TWO, 1'b1);
        checks++; if (pc_a1 !== 16'h0012 || int_level1 !== 2'd2 || stack_full1 !== 1'b0) begin
            failures++; $display("FAIL d1_reti pc=%h lvl=%0d full=%b exp=0012/2/0", pc_a1, int_level1, stack_full1); end
        do_update(PC_BASEX_PC, PC_OFFSETX_TWO, 1'b0);
        checks++; if (pc_a1 !== 16'h0004 || int_ack1 !== 2'b01 || int_level1 !== 2'd0) begin
            failures++; $display("FAIL d1_take0 pc=%h ack=%b lvl=%0d exp=0004/01/0", pc_a1, int_ack1, int_level1); end
        int_req = 2'b00;
        #2 rst_n = 1'b0;
        #1;
        $display("async reset mid-cycle -> pc=%h lvl=%0d full=%b", pc_a1, int_level1, stack_full1);
        checks++; if (pc_a1 !== 16'hFFFE || int_level1 !== 2'd2 || stack_full1 !== 1'b0) begin
            failures++; $display("FAIL async_reset pc=%h lvl=%0d full=%b exp=fffe/2/0", pc_a1, int_level1, stack_full1); end
        @(negedge clk);
        rst_n = 1'b1;
        do_update(PC_BASEX_PC, PC_OFFSETX_TWO, 1'b0);
        checks++; if (pc_a1 !== 16'h0000 || int_level1 !== 2'd2) begin
            failures++; $display("FAIL after_reset pc=%h lvl=%0d exp=0000/2", pc_a1, int_level1); end
    endtask

    initial begin
        test_reset();
        test_adder();
        test_int_take_nest();
        test_pending_lower();
        test_ret_err_int_en();
        test_mask();
        test_depth1_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
